cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
Sequencing stage directly upstream of the per-opcode instruction-word decoders in the control unit. It holds the instruction register, the 2-bit microstate and the 5-bit status register, all of which feed the decoders. It consumes each decoder's 33-bit control word, gates its side-effect bits when no instruction is live, and advances the microstate from the control word's next_state field. Instructions are accepted from fetch through a valid/ready handshake, one instruction at a time.

Parameters:
CW_WIDTH, 33, control word width; field layout fixed as below
MAX_STEPS, 4, maximum microsteps per instruction before abort
STATUS_RESET, 5'b00000, status register reset value

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_in  in  32  instruction word from fetch
instr_valid  in  1  instr_in is valid
instr_ready  out  1  sequencer will accept instr_in this cycle
stall  in  1  hold all state (memory wait)
cw_in  in  CW_WIDTH  control word from the selected decoder
status_in  in  5  ALU flags for this cycle
I  out  32  instruction register, to decoders
state  out  2  current microstate, to decoders
status  out  5  status register, to decoders
cw_out  out  CW_WIDTH  gated control word, to datapath
busy  out  1  instruction live in IR
retire  out  1  one-cycle pulse: instruction completed this cycle
step_fault  out  1  sticky: instruction exceeded MAX_STEPS

Behaviour:
- Field map of cw_in/cw_out, MSB first: alu_en[32], alu_bs[31], alu_fs[30:26], rf_b_en[25], rf_sa[24:20], rf_sb[19:15], rf_da[14:10], rf_w[9], ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_is[3], status_ld[2], next_state[1:0].
- Reset (async, reset_n low): I=0, state=2'b00, status=STATUS_RESET, busy=0, retire=0, step_fault=0, step counter=0. instr_ready=1 once reset_n is released.
- FSM has 2 states. IDLE: busy=0. EXEC: busy=1.
- instr_ready = !stall && !step_fault && (IDLE || (EXEC && cw_in[1:0]==2'b00)). Back-to-back issue with zero bubbles.
- Accept (instr_valid && instr_ready): I<=instr_in, state<=00, step counter<=0, go EXEC.
- EXEC step (!stall): state<=cw_in[1:0]; step counter +1; if cw_in[2], status<=status_in.
- Completion: cw_in[1:0]==00 in EXEC. retire=1 that cycle, registered in the same edge. If no new accept on that edge, go IDLE and I holds its value.
- cw_out in EXEC with !stall: cw_out = cw_in.
- cw_out in IDLE, during stall, or after step_fault: cw_out = cw_in with rf_w, ram_w, status_ld and pc_en forced to 0, and pc_fs forced to 00. Other bits pass through.
- stall=1: no register changes and retire=0. Stall takes priority over accept and completion.
- Step limit: if the step counter reaches MAX_STEPS-1 and cw_in[1:0]!=00, set step_fault=1, go IDLE, state<=00, instr_ready=0. Only reset_n clears step_fault.
- Step counter is 2 bits and does not wrap; the fault fires before any wrap can occur.
- Reset mid-instruction aborts immediately: no retire, and no pending status write.

Test Plan:
- Single-step instruction: present cw_in with next_state=00 and rf_w=1, then accept 0xF2A0_0001. Required: busy=1 for 1 cycle, retire pulses once, cw_out[9]=1, instr_ready stays 1, next instruction is accepted on the following edge.
- Two-step MOVK-style: cw_in next_state=01, then 00. Required: state goes 00→01→00, retire on the 2nd EXEC cycle, pc_fs=00 then 01 at cw_out.
- Stall and status: stall=1 for 3 cycles mid-instruction with status_ld=1 and status_in=5'b10101. Required: state, I and status are frozen; rf_w and pc_en at cw_out are 0. After stall drops, status=10101 on the following edge.
- Step fault: cw_in next_state held at 01 indefinitely. Required: step_fault=1 after 4 EXEC steps, state=00, busy=0, instr_ready=0, no retire; reset_n clears all of these.
- Idle gating: no instr_valid, cw_in all-ones. Required: cw_out = all-ones except bits 9, 7, 6, 5, 4, 2 = 0.
- Async reset mid-EXEC: assert reset_n low between clock edges. Required: all outputs reach reset values immediately, and no retire pulse occurs.

Source files
------------

// File: rtl/cu_sequencer_if.sv
// Bundle between fetch, the per-opcode decoders, the datapath and the
// control-unit sequencer.
//
// Handshake: an instruction transfers on a rising clock edge where both
// instr_valid and instr_ready are high. The sequencer only raises
// instr_ready when it can take the word on that same edge. The fetch side
// keeps instr_in steady while instr_valid is high and the word has not been
// taken.
interface cu_sequencer_if #(
    parameter int CW_WIDTH = 33
);
    logic [31:0]         instr_in;
    logic                instr_valid;
    logic                instr_ready;
    logic                stall;
    logic [CW_WIDTH-1:0] cw_in;
    logic [4:0]          status_in;
    logic [31:0]         I;
    logic [1:0]          state;
    logic [4:0]          status;
    logic [CW_WIDTH-1:0] cw_out;
    logic                busy;
    logic                retire;
    logic                step_fault;
    logic                fsm_dbg;    // 1 = EXEC, 0 = IDLE

    modport master (
        output instr_in, instr_valid, stall, cw_in, status_in,
        input  instr_ready, I, state, status, cw_out, busy, retire,
               step_fault, fsm_dbg
    );

    modport slave (
        input  instr_in, instr_valid, stall, cw_in, status_in,
        output instr_ready, I, state, status, cw_out, busy, retire,
               step_fault, fsm_dbg
    );
endinterface

// File: rtl/cu_sequencer.sv
// Control-unit sequencer. It holds the instruction register, the microstate
// and the status register that feed the decoders. It takes the selected
// decoder's control word and masks the side-effect bits of that word whenever
// no instruction step is live. A step counter aborts runaway instructions.
module cu_sequencer #(
    parameter int         CW_WIDTH     = 33,
    parameter int         MAX_STEPS    = 4,
    parameter logic [4:0] STATUS_RESET = 5'b00000
) (
    input logic           clock,
    input logic           reset_n,
    cu_sequencer_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } fsm_t;

    // Side-effect bits of the control word: rf_w[9], ram_w[7], pc_en[6],
    // pc_fs[5:4] and status_ld[2].
    localparam logic [CW_WIDTH-1:0] GATE_MASK = CW_WIDTH'(33'h0_0000_02F4);
    localparam logic [1:0]          LAST_STEP = 2'(MAX_STEPS - 1);

    fsm_t        fsm_q, fsm_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  ustate_q, ustate_d;
    logic [4:0]  status_q, status_d;
    logic [1:0]  step_q, step_d;
    logic        fault_q, fault_d;

    logic        ns_done;
    logic        live_step;
    logic        ready;
    logic        accept;
    logic        retire_c;

    assign ns_done   = (bus.cw_in[1:0] == 2'b00);
    assign live_step = (fsm_q == EXEC) && !bus.stall;
    assign ready     = !bus.stall && !fault_q &&
                       ((fsm_q == IDLE) || ((fsm_q == EXEC) && ns_done));
    assign accept    = bus.instr_valid && ready;

    // State register. Reset aborts any live instruction and drops a pending status write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q    <= IDLE;
            ir_q     <= 32'h0;
            ustate_q <= 2'b00;
            status_q <= STATUS_RESET;
            step_q   <= 2'b00;
            fault_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            ir_q     <= ir_d;
            ustate_q <= ustate_d;
            status_q <= status_d;
            step_q   <= step_d;
            fault_q  <= fault_d;
        end
    end

    // Next state: execute a step, retire or abort, then let an accept override.
    always_comb begin
        fsm_d    = fsm_q;
        ir_d     = ir_q;
        ustate_d = ustate_q;
        status_d = status_q;
        step_d   = step_q;
        fault_d  = fault_q;
        retire_c = 1'b0;

        if (live_step) begin
            ustate_d = bus.cw_in[1:0];
            if (step_q != 2'b11) begin
                step_d = step_q + 2'd1;
            end
            if (bus.cw_in[2]) begin
                status_d = bus.status_in;
            end
            if (ns_done) begin
                retire_c = 1'b1;
                fsm_d    = IDLE;
            end else if (step_q == LAST_STEP) begin
                // Runaway instruction: abort it and refuse further issue until reset.
                fault_d  = 1'b1;
                fsm_d    = IDLE;
                ustate_d = 2'b00;
            end
        end

        // A new instruction may be taken on the same edge as a retire.
        if (accept) begin
            ir_d     = bus.instr_in;
            ustate_d = 2'b00;
            step_d   = 2'b00;
            fsm_d    = EXEC;
        end
    end

    // Output drive: the control word passes whole only during a live, unstalled step.
    always_comb begin
        if (live_step && !fault_q) begin
            bus.cw_out = bus.cw_in;
        end else begin
            bus.cw_out = bus.cw_in & ~GATE_MASK;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.I           = ir_q;
    assign bus.state       = ustate_q;
    assign bus.status      = status_q;
    assign bus.busy        = (fsm_q == EXEC);
    assign bus.retire      = retire_c;
    assign bus.step_fault  = fault_q;
    assign bus.fsm_dbg     = (fsm_q == EXEC);
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer. Inputs change 2 ns after a rising edge.
// Outputs are sampled 1 ns after that, which keeps every sample away from the clock edges.
module tb_cu_sequencer;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    localparam logic [32:0] ALL_ONES = 33'h1_FFFF_FFFF;
    localparam logic [32:0] IDLE_ONES = 33'h1_FFFF_FD0B;

    cu_sequencer_if #(.CW_WIDTH(33)) bus ();

    cu_sequencer #(
        .CW_WIDTH    (33),
        .MAX_STEPS   (4),
        .STATUS_RESET(5'b00000)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset_n         = 1'b0;
        bus.instr_in    = 32'h0;
        bus.instr_valid = 1'b0;
        bus.stall       = 1'b0;
        bus.cw_in       = 33'h0;
        bus.status_in   = 5'h0;

        // Reset values
        #1;
        chk("rst_I", 64'(bus.I), 64'h0);
        chk("rst_state", 64'(bus.state), 64'h0);
        chk("rst_status", 64'(bus.status), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_retire", 64'(bus.retire), 64'h0);
        chk("rst_fault", 64'(bus.step_fault), 64'h0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.instr_ready), 64'h1);

        // Single-step instruction followed by a back-to-back issue
        bus.cw_in       = 33'h200;
        bus.instr_in    = 32'hF2A0_0001;
        bus.instr_valid = 1'b1;
        #1;
        chk("ss_idle_cw", 64'(bus.cw_out), 64'h0);
        tick();
        bus.instr_in = 32'h1234_5678;
        #1;
        chk("ss_busy", 64'(bus.busy), 64'h1);
        chk("ss_I", 64'(bus.I), 64'hF2A0_0001);
        chk("ss_retire", 64'(bus.retire), 64'h1);
        chk("ss_cw", 64'(bus.cw_out), 64'h200);
        chk("ss_ready", 64'(bus.instr_ready), 64'h1);
        tick();
        bus.instr_valid = 1'b0;
        #1;
        chk("b2b_busy", 64'(bus.busy), 64'h1);
        chk("b2b_I", 64'(bus.I), 64'h1234_5678);
        chk("b2b_retire", 64'(bus.retire), 64'h1);
        tick();
        #1;
        chk("b2b_idle", 64'(bus.busy), 64'h0);
        chk("b2b_no_retire", 64'(bus.retire), 64'h0);
        chk("b2b_I_hold", 64'(bus.I), 64'h1234_5678);

        // Two-step instruction
        bus.cw_in       = 33'h1;
        bus.instr_in    = 32'hA000_0002;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        #1;
        chk("ts_state0", 64'(bus.state), 64'h0);
        chk("ts_retire0", 64'(bus.retire), 64'h0);
        chk("ts_cw0", 64'(bus.cw_out), 64'h1);
        chk("ts_ready0", 64'(bus.instr_ready), 64'h0);
        tick();
        bus.cw_in = 33'h10;
        #1;
        chk("ts_state1", 64'(bus.state), 64'h1);
        chk("ts_retire1", 64'(bus.retire), 64'h1);
        chk("ts_pcfs1", 64'(bus.cw_out[5:4]), 64'h1);
        tick();
        #1;
        chk("ts_state_end", 64'(bus.state), 64'h0);
        chk("ts_idle", 64'(bus.busy), 64'h0);

        // Stall with a pending status load
        bus.cw_in       = 33'h1;
        bus.instr_in    = 32'hB000_0003;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.cw_in       = 33'h245;
        bus.status_in   = 5'b10101;
        bus.stall       = 1'b1;
        #1;
        chk("st_cw_gated", 64'(bus.cw_out), 64'h1);
        chk("st_ready", 64'(bus.instr_ready), 64'h0);
        chk("st_retire", 64'(bus.retire), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("st_state", 64'(bus.state), 64'h0);
            chk("st_I", 64'(bus.I), 64'hB000_0003);
            chk("st_status", 64'(bus.status), 64'h0);
            chk("st_busy", 64'(bus.busy), 64'h1);
        end
        bus.stall = 1'b0;
        #1;
        chk("st_cw_live", 64'(bus.cw_out), 64'h245);
        tick();
        bus.cw_in = 33'h0;
        #1;
        chk("st_status_ld", 64'(bus.status), 64'h15);
        chk("st_state1", 64'(bus.state), 64'h1);
        chk("st_retire_end", 64'(bus.retire), 64'h1);
        tick();
        #1;
        chk("st_idle", 64'(bus.busy), 64'h0);

        // Step fault: next_state stuck at 01
        bus.cw_in       = 33'h1;
        bus.instr_in    = 32'hC000_0004;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("sf_pre_fault", 64'(bus.step_fault), 64'h0);
        chk("sf_pre_busy", 64'(bus.busy), 64'h1);
        chk("sf_pre_retire", 64'(bus.retire), 64'h0);
        tick();
        bus.instr_valid = 1'b1;
        #1;
        chk("sf_fault", 64'(bus.step_fault), 64'h1);
        chk("sf_state", 64'(bus.state), 64'h0);
        chk("sf_busy", 64'(bus.busy), 64'h0);
        chk("sf_ready", 64'(bus.instr_ready), 64'h0);
        chk("sf_retire", 64'(bus.retire), 64'h0);
        tick();
        bus.instr_valid = 1'b0;
        #1;
        chk("sf_sticky", 64'(bus.step_fault), 64'h1);
        chk("sf_no_accept", 64'(bus.busy), 64'h0);
        reset_n = 1'b0;
        #1;
        chk("sf_rst_fault", 64'(bus.step_fault), 64'h0);
        chk("sf_rst_I", 64'(bus.I), 64'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("sf_rst_ready", 64'(bus.instr_ready), 64'h1);

        // Idle gating with an all-ones control word
        bus.cw_in = ALL_ONES;
        #1;
        chk("ig_cw", 64'(bus.cw_out), 64'(IDLE_ONES));
        tick();
        #1;
        chk("ig_busy", 64'(bus.busy), 64'h0);

        // Asynchronous reset in the middle of EXEC
        bus.cw_in       = 33'h5;
        bus.status_in   = 5'b01010;
        bus.instr_in    = 32'hD000_0005;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        #1;
        chk("ar_busy_pre", 64'(bus.busy), 64'h1);
        chk("ar_cw_pre", 64'(bus.cw_out), 64'h5);
        reset_n = 1'b0;
        #1;
        chk("ar_I", 64'(bus.I), 64'h0);
        chk("ar_busy", 64'(bus.busy), 64'h0);
        chk("ar_retire", 64'(bus.retire), 64'h0);
        chk("ar_state", 64'(bus.state), 64'h0);
        chk("ar_cw", 64'(bus.cw_out), 64'h1);
        tick();
        #1;
        chk("ar_status", 64'(bus.status), 64'h0);
        reset_n = 1'b1;
        tick();
        #1;
        chk("ar_status_after", 64'(bus.status), 64'h0);
        chk("ar_idle_after", 64'(bus.busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
